// File: rtl/fantasticfft_pkg.sv
// Shared types and helpers for the streaming radix-2 FFT: FSM state, bit reversal,
// elaboration-time twiddle generation and symmetric saturation.
package fantasticfft_pkg;

    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

    localparam real PI = 3.14159265358979323846;

    function automatic int bitrev(input int k, input int bits);
        int r;
        r = 0;
        for (int i = 0; i < bits; i++) begin
            r = (r << 1) | ((k >> i) & 1);
        end
        return r;
    endfunction

    // W_N^j = cos(2*pi*j/N) - i*sin(2*pi*j/N), rounded half-up to frac fractional bits
    function automatic int twiddle_re(input int n, input int j, input int frac);
        real ang;
        real v;
        ang = 2.0 * PI * real'(j) / real'(n);
        v   = $cos(ang) * real'(1 << frac);
        return int'($floor(v + 0.5));
    endfunction

    function automatic int twiddle_im(input int n, input int j, input int frac);
        real ang;
        real v;
        ang = 2.0 * PI * real'(j) / real'(n);
        v   = -$sin(ang) * real'(1 << frac);
        return int'($floor(v + 0.5));
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fantasticfft_butterfly.sv
// Combinational radix-2 DIT butterfly: ya = a + b*w, yb = a - b*w, rounded and saturated.
// FANTASTICFFT_STAGE_SCALE_EN: halve each output (round-half-up) so a full FFT yields DFT/N.
module fantasticfft_butterfly
    import fantasticfft_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int FRAC_SIZE = 8
) (
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [DATA_W-1:0] b_re,
    input  logic signed [DATA_W-1:0] b_im,
    input  logic signed [DATA_W-1:0] tw_re,
    input  logic signed [DATA_W-1:0] tw_im,
    output logic signed [DATA_W-1:0] ya_re,
    output logic signed [DATA_W-1:0] ya_im,
    output logic signed [DATA_W-1:0] yb_re,
    output logic signed [DATA_W-1:0] yb_im
);

    function automatic logic signed [63:0] round_shift(input logic signed [63:0] v, input int sh);
        return (v + (64'sd1 <<< (sh - 1))) >>> sh;
    endfunction

    // 64-bit intermediates hold the full 2*DATA_W+1 product sums without overflow
    logic signed [63:0] ar, ai, br, bi, wr, wi;
    logic signed [63:0] t_re, t_im;
    logic signed [63:0] s_re, s_im, d_re, d_im;

    assign ar = 64'(a_re);
    assign ai = 64'(a_im);
    assign br = 64'(b_re);
    assign bi = 64'(b_im);
    assign wr = 64'(tw_re);
    assign wi = 64'(tw_im);

    assign t_re = saturate(round_shift(br * wr - bi * wi, FRAC_SIZE), DATA_W);
    assign t_im = saturate(round_shift(br * wi + bi * wr, FRAC_SIZE), DATA_W);

`ifdef FANTASTICFFT_STAGE_SCALE_EN
    assign s_re = round_shift(ar + t_re, 1);
    assign s_im = round_shift(ai + t_im, 1);
    assign d_re = round_shift(ar - t_re, 1);
    assign d_im = round_shift(ai - t_im, 1);
`else
    assign s_re = ar + t_re;
    assign s_im = ai + t_im;
    assign d_re = ar - t_re;
    assign d_im = ai - t_im;
`endif

    assign ya_re = DATA_W'(saturate(s_re, DATA_W));
    assign ya_im = DATA_W'(saturate(s_im, DATA_W));
    assign yb_re = DATA_W'(saturate(d_re, DATA_W));
    assign yb_im = DATA_W'(saturate(d_im, DATA_W));

endmodule

// File: rtl/fantasticfft_fft_stream.sv
// Streaming N-point in-place radix-2 DIT FFT: load (bit-reversed), compute, unload (natural order).
// Optional FANTASTICFFT_STAGE_SCALE_EN selects per-stage halving inside the butterfly.
module fantasticfft_fft_stream
    import fantasticfft_pkg::*;
#(
    parameter  int INT_SIZE  = 8,
    parameter  int FRAC_SIZE = 8,
    parameter  int N_POINTS  = 8,
    localparam int W         = INT_SIZE + FRAC_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_re,
    input  logic signed [W-1:0] in_im,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_re,
    output logic signed [W-1:0] out_im,
    output logic                out_last,
    output logic                busy
);

    localparam int AW    = $clog2(N_POINTS);
    localparam int TW_AW = AW - 1;
    localparam int SW    = $clog2(AW + 1);

    if (N_POINTS < 4 || N_POINTS > 64 || (N_POINTS & (N_POINTS - 1)) != 0) begin : g_bad_n
        $error("N_POINTS must be a power of two in 4..64");
    end
    if (INT_SIZE < 2) begin : g_bad_int
        $error("INT_SIZE must be at least 2 so that twiddle 1.0 is representable");
    end
    if (W > 31 || FRAC_SIZE < 1) begin : g_bad_w
        $error("word width must be 2..31 bits with at least one fractional bit");
    end

    typedef struct packed {
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
    } cplx_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     cnt;
    logic [TW_AW-1:0]  bf;
    logic [SW-1:0]     stg;
    cplx_t             mem [N_POINTS];

    logic signed [W-1:0] tw_re_tab [N_POINTS/2];
    logic signed [W-1:0] tw_im_tab [N_POINTS/2];

    for (genvar j = 0; j < N_POINTS / 2; j++) begin : g_tw
        assign tw_re_tab[j] = W'(twiddle_re(N_POINTS, j, FRAC_SIZE));
        assign tw_im_tab[j] = W'(twiddle_im(N_POINTS, j, FRAC_SIZE));
    end

    // Stage s pairs (a, a+2^s); j = butterfly index within its group scaled to the N-point table
    logic [AW-1:0]    bfx, span, jj, addr_a, addr_b, load_addr;
    logic [TW_AW-1:0] tw_idx;

    always_comb begin
        bfx       = {1'b0, bf};
        span      = AW'(1) << stg;
        jj        = bfx & (span - AW'(1));
        addr_a    = ((bfx >> stg) << (stg + 1'b1)) | jj;
        addr_b    = addr_a | span;
        tw_idx    = TW_AW'(jj << (AW - 1 - int'(stg)));
        load_addr = AW'(bitrev(int'(cnt), AW));
    end

    cplx_t op_a, op_b, res_a, res_b;

    assign op_a = mem[addr_a];
    assign op_b = mem[addr_b];

    fantasticfft_butterfly #(
        .DATA_W    (W),
        .FRAC_SIZE (FRAC_SIZE)
    ) u_bfly (
        .a_re  (op_a.re),
        .a_im  (op_a.im),
        .b_re  (op_b.re),
        .b_im  (op_b.im),
        .tw_re (tw_re_tab[tw_idx]),
        .tw_im (tw_im_tab[tw_idx]),
        .ya_re (res_a.re),
        .ya_im (res_a.im),
        .yb_re (res_b.re),
        .yb_im (res_b.im)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        out_re    = '0;
        out_im    = '0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && cnt == AW'(N_POINTS - 1)) state_nxt = COMPUTE;
            end
            COMPUTE: begin
                busy = 1'b1;
                if (bf == TW_AW'(N_POINTS / 2 - 1) && stg == SW'(AW - 1)) state_nxt = UNLOAD;
            end
            UNLOAD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_re    = mem[cnt].re;
                out_im    = mem[cnt].im;
                out_last  = (cnt == AW'(N_POINTS - 1));
                if (out_ready && cnt == AW'(N_POINTS - 1)) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    // N and N/2 are powers of two, so the counters wrap to zero on their own at frame/stage end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            bf  <= '0;
            stg <= '0;
        end else begin
            case (state)
                LOAD:    if (in_valid) cnt <= cnt + 1'b1;
                COMPUTE: begin
                    bf <= bf + 1'b1;
                    if (bf == TW_AW'(N_POINTS / 2 - 1)) begin
                        stg <= (stg == SW'(AW - 1)) ? '0 : stg + 1'b1;
                    end
                end
                UNLOAD:  if (out_ready) cnt <= cnt + 1'b1;
                default: cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == LOAD && in_valid) begin
            mem[load_addr] <= '{re: in_re, im: in_im};
        end else if (state == COMPUTE) begin
            mem[addr_a] <= res_a;
            mem[addr_b] <= res_b;
        end
    end

endmodule

// File: tb/tb_fantasticfft_fft_stream.sv
// Directed bench for the 8-point streaming FFT (INT_SIZE=8, FRAC_SIZE=8, 1.0 = 16'h0100).
module tb_fantasticfft_fft_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_re;
    logic [15:0] in_im;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_re;
    logic [15:0] out_im;
    logic        out_last;
    logic        busy;

    int total = 0;
    int bad   = 0;

`ifdef FANTASTICFFT_STAGE_SCALE_EN
    localparam logic [15:0] IMP_BIN = 16'h0020;
    localparam logic [15:0] DC_BIN0 = 16'h0100;
    localparam logic [15:0] ALT_B4  = 16'h0100;
`else
    localparam logic [15:0] IMP_BIN = 16'h0100;
    localparam logic [15:0] DC_BIN0 = 16'h0800;
    localparam logic [15:0] ALT_B4  = 16'h0800;
`endif

    always #5 clk = ~clk;

    fantasticfft_fft_stream #(
        .INT_SIZE  (8),
        .FRAC_SIZE (8),
        .N_POINTS  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while in LOAD; returns at the negedge after the last accept.
    task automatic send_frame(input logic [15:0] re [8], input string tag);
        for (int k = 0; k < 8; k++) begin
            int g;
            in_valid = 1'b1;
            in_re    = re[k];
            in_im    = 16'h0000;
            g = 0;
            while (!in_ready && g < 50) begin
                @(negedge clk);
                g++;
            end
            if (g >= 50) chk({tag, "_in_ready_timeout"}, 32'(g), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic recv_frame(input logic [15:0] er [8], input logic [15:0] ei [8],
                              input bit stall, input string tag);
        int idx;
        int cyc;
        bit rdy;
        idx = 0;
        cyc = 0;
        while (idx < 8 && cyc < 300) begin
            if (out_valid) begin
                chk($sformatf("%s_bin%0d_re", tag, idx), 32'(out_re), 32'(er[idx]));
                chk($sformatf("%s_bin%0d_im", tag, idx), 32'(out_im), 32'(ei[idx]));
                chk($sformatf("%s_bin%0d_last", tag, idx), 32'(out_last), 32'(idx == 7));
                rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                out_ready = rdy;
                if (rdy) idx++;
            end else begin
                out_ready = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        if (idx < 8) chk({tag, "_recv_timeout"}, 32'(idx), 32'd8);
        out_ready = 1'b0;
        chk({tag, "_done_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_done_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    logic [15:0] x    [8];
    logic [15:0] e_re [8];
    logic [15:0] e_im [8];
    logic [15:0] zero8 [8];
    int lat;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        out_ready = 1'b0;
        zero8     = '{default: 16'h0000};
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_re", 32'(out_re), 32'd0);
        chk("rst_out_im", 32'(out_im), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Impulse; junk held on in_valid during COMPUTE must be ignored
        x = '{16'h0100, 0, 0, 0, 0, 0, 0, 0};
        send_frame(x, "imp");
        in_valid = 1'b1;
        in_re    = 16'h1234;
        lat      = 1;
        chk("imp_compute_in_ready", 32'(in_ready), 32'd0);
        chk("imp_compute_busy", 32'(busy), 32'd1);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        chk("imp_latency", 32'(lat), 32'd13);
        e_re = '{default: IMP_BIN};
        recv_frame(e_re, zero8, 1'b0, "imp");

        // DC
        x = '{default: 16'h0100};
        send_frame(x, "dc");
        e_re = '{DC_BIN0, 0, 0, 0, 0, 0, 0, 0};
        recv_frame(e_re, zero8, 1'b0, "dc");

        // Alternating +1/-1 -> energy only in bin 4
        x = '{16'h0100, 16'hFF00, 16'h0100, 16'hFF00, 16'h0100, 16'hFF00, 16'h0100, 16'hFF00};
        send_frame(x, "alt");
        e_re = '{0, 0, 0, 0, ALT_B4, 0, 0, 0};
        recv_frame(e_re, zero8, 1'b0, "alt");

        // Full-scale DC saturates bin 0 instead of wrapping
        x = '{default: 16'h7FFF};
        send_frame(x, "sat");
        e_re = '{16'h7FFF, 0, 0, 0, 0, 0, 0, 0};
        recv_frame(e_re, zero8, 1'b0, "sat");

`ifndef FANTASTICFFT_STAGE_SCALE_EN
        // Delayed impulse: X[m] = W8^m exercises every twiddle; 50% random backpressure
        x = '{0, 16'h0100, 0, 0, 0, 0, 0, 0};
        send_frame(x, "twd");
        e_re = '{16'h0100, 16'h00B5, 16'h0000, 16'hFF4B, 16'hFF00, 16'hFF4B, 16'h0000, 16'h00B5};
        e_im = '{16'h0000, 16'hFF4B, 16'hFF00, 16'hFF4B, 16'h0000, 16'h00B5, 16'h0100, 16'h00B5};
        recv_frame(e_re, e_im, 1'b1, "twd");
`endif

        // Reset asserted mid-COMPUTE between clock edges
        x = '{default: 16'h0100};
        send_frame(x, "mid");
        repeat (3) @(negedge clk);
        chk("mid_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_re", 32'(out_re), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        x = '{16'h0100, 0, 0, 0, 0, 0, 0, 0};
        send_frame(x, "post");
        e_re = '{default: IMP_BIN};
        recv_frame(e_re, zero8, 1'b1, "post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
